// File: rtl/ins_decode_ctrl.sv
// Multicycle control for a MIPS subset: IF/ID/EX/MEM/WB sequencer, selects decoded from the latched ir.
// 2-5 cycles per instruction; hold freezes state, ir and retired_cnt and masks every strobe.
module ins_decode_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [31:0]      ins_in,
  output logic             npc_sel,
  output logic             isJump,
  output logic [15:0]      npc_out_imm16,
  output logic [25:0]      npc_out_imm26,
  output logic             pc_we,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             illegal_ins,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      cur_state, nxt_state;
  logic [31:0] ir;
  logic [5:0]  opcode, funct;
  logic        is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  assign is_addu = (opcode == 6'h00) && (funct == 6'h21);
  assign is_subu = (opcode == 6'h00) && (funct == 6'h23);
  assign is_ori  = (opcode == 6'h0D);
  assign is_lui  = (opcode == 6'h0F);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_j    = (opcode == 6'h02);
  assign legal   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign npc_out_imm16 = ir[15:0];
  assign npc_out_imm26 = ir[25:0];
  assign state         = cur_state;

  // ir resets to 0, which decodes as illegal, so every select is 0 during reset.
  assign alu_op     = is_lui ? 3'd3 :
                      is_ori ? 3'd2 :
                      (is_subu | is_beq) ? 3'd1 : 3'd0;
  assign ext_op     = is_lui ? 2'd2 :
                      (is_lw | is_sw) ? 2'd1 : 2'd0;
  assign alu_src    = is_ori | is_lui | is_lw | is_sw;
  assign reg_dst    = is_addu | is_subu;
  assign mem_to_reg = is_lw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= S_IF;
      ir          <= '0;
      retired_cnt <= '0;
    end else if (!hold) begin
      cur_state <= nxt_state;
      if (cur_state == S_IF) ir <= ins_in;
      if (pc_we) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    npc_sel     = 1'b0;
    isJump      = 1'b0;
    illegal_ins = 1'b0;
    case (cur_state)
      S_IF: nxt_state = S_ID;
      S_ID: begin
        if (!legal) begin
          illegal_ins = 1'b1;
          pc_we       = 1'b1;
          nxt_state   = S_IF;
        end else if (is_j) begin
          isJump    = 1'b1;
          pc_we     = 1'b1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_EX;
        end
      end
      S_EX: begin
        if (is_beq) begin
          npc_sel   = 1'b1;
          pc_we     = 1'b1;
          nxt_state = S_IF;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_we    = 1'b1;
          pc_we     = 1'b1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        nxt_state = S_IF;
      end
      default: nxt_state = S_IF;
    endcase
    // Holding keeps the current state, so its strobe fires once hold drops.
    if (hold) begin
      nxt_state   = cur_state;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      mem_we      = 1'b0;
      npc_sel     = 1'b0;
      isJump      = 1'b0;
      illegal_ins = 1'b0;
    end
  end

endmodule

// File: tb/tb_ins_decode_ctrl.sv
// Scoreboard bench for ins_decode_ctrl: per-cycle expectations queued with the stimulus.
module tb_ins_decode_ctrl;
  localparam int CW = 3;

  // strobe vector order: {pc_we, reg_we, mem_we, npc_sel, isJump, illegal_ins}
  localparam logic [5:0] PC = 6'b100000, RW = 6'b010000, MW = 6'b001000;
  localparam logic [5:0] NS = 6'b000100, JP = 6'b000010, IL = 6'b000001;
  // state sequences, cycle 0 in the low 3 bits
  localparam logic [14:0] SQ2  = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
  localparam logic [14:0] SQ3  = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ4R = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ4M = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ5  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  // selects vector order: {reg_dst, alu_src, mem_to_reg, alu_op[2:0], ext_op[1:0]}
  localparam logic [7:0] SEL_ADDU = 8'b1_0_0_000_00, SEL_SUBU = 8'b1_0_0_001_00;
  localparam logic [7:0] SEL_ORI  = 8'b0_1_0_010_00, SEL_LUI  = 8'b0_1_0_011_10;
  localparam logic [7:0] SEL_LW   = 8'b0_1_1_000_01, SEL_SW   = 8'b0_1_0_000_01;
  localparam logic [7:0] SEL_BEQ  = 8'b0_0_0_001_00;

  logic clk, rst, hold;
  logic [31:0] ins_in;
  logic npc_sel, isJump, pc_we, reg_we, reg_dst, alu_src, mem_we, mem_to_reg, illegal_ins;
  logic [15:0] npc_out_imm16;
  logic [25:0] npc_out_imm26;
  logic [4:0] rs, rt, rd;
  logic [2:0] alu_op, state;
  logic [1:0] ext_op;
  logic [CW-1:0] retired_cnt;

  ins_decode_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .ins_in(ins_in),
    .npc_sel(npc_sel), .isJump(isJump), .npc_out_imm16(npc_out_imm16),
    .npc_out_imm26(npc_out_imm26), .pc_we(pc_we), .rs(rs), .rt(rt), .rd(rd),
    .reg_we(reg_we), .reg_dst(reg_dst), .alu_src(alu_src), .mem_we(mem_we),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .ext_op(ext_op),
    .illegal_ins(illegal_ins), .state(state), .retired_cnt(retired_cnt)
  );

  wire [8:0] cyc_obs = {state, pc_we, reg_we, mem_we, npc_sel, isJump, illegal_ins};
  wire [7:0] sel_obs = {reg_dst, alu_src, mem_to_reg, alu_op, ext_op};
  wire [76:0] all_obs = {npc_sel, isJump, npc_out_imm16, npc_out_imm26, pc_we, rs, rt, rd,
                         reg_we, reg_dst, alu_src, mem_we, mem_to_reg, alu_op, ext_op,
                         illegal_ins, state, retired_cnt};

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  st;
    logic [5:0]  stb;
    logic        hd;
    logic        last;
    logic [7:0]  selm;
    logic [7:0]  sel;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_cyc(input logic [31:0] ins, input logic [2:0] st, input logic [5:0] stb,
                                   input logic hd, input logic last, input logic [7:0] selm,
                                   input logic [7:0] sel);
    exp_t e;
    e.ins = ins; e.st = st; e.stb = stb; e.hd = hd; e.last = last; e.selm = selm; e.sel = sel;
    q.push_back(e);
  endfunction

  function automatic void push_ins(input logic [31:0] ins, input int n, input logic [14:0] sts,
                                   input logic [5:0] fin, input logic [7:0] selm, input logic [7:0] sel);
    for (int i = 0; i < n; i++)
      push_cyc(ins, sts[3*i +: 3], (i == n - 1) ? fin : 6'b0, 1'b0, i == n - 1, selm, sel);
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_obs !== '0) begin
      failures++; $display("FAIL reset_outputs: got=%h want=0", all_obs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (all_obs !== '0) begin
      failures++; $display("FAIL reset_release_outputs: got=%h want=0", all_obs);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    push_ins(32'h00221821, 4, SQ4R, PC | RW, 8'hFF, SEL_ADDU);
    push_ins(32'h00221823, 4, SQ4R, PC | RW, 8'hFF, SEL_SUBU);
    push_ins(32'h34220005, 4, SQ4R, PC | RW, 8'hFF, SEL_ORI);
    push_ins(32'h3C011234, 4, SQ4R, PC | RW, 8'hFF, SEL_LUI);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL alu_cycle ins=%h: got=%h want=%h", e.ins, cyc_obs, {e.st, e.stb});
      end
      if (e.last) begin
        checks++;
        if ({sel_obs & e.selm, rs, rt, rd, npc_out_imm26, npc_out_imm16} !==
            {e.sel & e.selm, e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[25:0], e.ins[15:0]}) begin
          failures++; $display("FAIL alu_fields ins=%h: sel got=%b want=%b rs/rt/rd=%0d/%0d/%0d",
                               e.ins, sel_obs, e.sel, rs, rt, rd);
        end
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL alu_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_flow();
    exp_t e;
    push_ins(32'h10220004, 3, SQ3, PC | NS, 8'hFF, SEL_BEQ);
    push_ins(32'h08000010, 2, SQ2, PC | JP, 8'h00, 8'h00);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL flow_cycle ins=%h: got=%h want=%h", e.ins, cyc_obs, {e.st, e.stb});
      end
      if (e.last) begin
        checks++;
        if ({sel_obs & e.selm, rs, rt, rd, npc_out_imm26, npc_out_imm16} !==
            {e.sel & e.selm, e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[25:0], e.ins[15:0]}) begin
          failures++; $display("FAIL flow_fields ins=%h: imm16=%h imm26=%h sel=%b",
                               e.ins, npc_out_imm16, npc_out_imm26, sel_obs);
        end
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL flow_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_mem();
    exp_t e;
    push_ins(32'h8C850008, 5, SQ5, PC | RW, 8'hFF, SEL_LW);
    push_ins(32'hAC850008, 4, SQ4M, PC | MW, 8'hFF, SEL_SW);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL mem_cycle ins=%h: got=%h want=%h", e.ins, cyc_obs, {e.st, e.stb});
      end
      if (e.last) begin
        checks++;
        if ({sel_obs & e.selm, rs, rt, rd, npc_out_imm26, npc_out_imm16} !==
            {e.sel & e.selm, e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[25:0], e.ins[15:0]}) begin
          failures++; $display("FAIL mem_fields ins=%h: sel got=%b want=%b rt=%0d",
                               e.ins, sel_obs, e.sel, rt);
        end
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL mem_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    push_ins(32'hFC000000, 2, SQ2, PC | IL, 8'h00, 8'h00);
    push_ins(32'h00221822, 2, SQ2, PC | IL, 8'h00, 8'h00);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL illegal_cycle ins=%h: got=%h want=%h", e.ins, cyc_obs, {e.st, e.stb});
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL illegal_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_ins(32'h08000004, 2, SQ2, PC | JP, 8'h00, 8'h00);
    push_ins(32'h8C220010, 5, SQ5, PC | RW, 8'hFF, SEL_LW);
    push_ins(32'h1063FFFE, 3, SQ3, PC | NS, 8'hFF, SEL_BEQ);
    push_ins(32'h7C000000, 2, SQ2, PC | IL, 8'h00, 8'h00);
    push_ins(32'h00A62021, 4, SQ4R, PC | RW, 8'hFF, SEL_ADDU);
    push_ins(32'hAFBF0004, 4, SQ4M, PC | MW, 8'hFF, SEL_SW);
    push_ins(32'h3C0AFFFF, 4, SQ4R, PC | RW, 8'hFF, SEL_LUI);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL b2b_cycle ins=%h: got=%h want=%h", e.ins, cyc_obs, {e.st, e.stb});
      end
      if (e.last) begin
        checks++;
        if ({sel_obs & e.selm, rs, rt, rd, npc_out_imm26, npc_out_imm16} !==
            {e.sel & e.selm, e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[25:0], e.ins[15:0]}) begin
          failures++; $display("FAIL b2b_fields ins=%h: sel got=%b want=%b", e.ins, sel_obs, e.sel);
        end
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL b2b_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_hold();
    exp_t e;
    ins_in = 32'h00221821;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd2) begin
      failures++; $display("FAIL pre_reset_state: got=%0d want=2", state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_obs !== '0) begin
      failures++; $display("FAIL midreset_outputs: got=%h want=0", all_obs);
    end
    @(posedge clk); #1;
    checks++;
    if (all_obs !== '0) begin
      failures++; $display("FAIL midreset_held: got=%h want=0", all_obs);
    end
    rst = 1'b0;
    exp_cnt = '0;
    push_cyc(32'h00221821, 3'd0, 6'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push_cyc(32'h00221821, 3'd1, 6'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push_cyc(32'h00221821, 3'd2, 6'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++)
      push_cyc(32'h00221821, 3'd4, 6'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    push_cyc(32'h00221821, 3'd4, PC | RW, 1'b0, 1'b1, 8'hFF, SEL_ADDU);
    push_ins(32'h08000010, 2, SQ2, PC | JP, 8'h00, 8'h00);
    while (q.size() != 0) begin
      e = q.pop_front();
      ins_in = e.ins; hold = e.hd;
      @(negedge clk);
      checks++;
      if (cyc_obs !== {e.st, e.stb}) begin
        failures++; $display("FAIL hold_cycle ins=%h hold=%b: got=%h want=%h",
                             e.ins, e.hd, cyc_obs, {e.st, e.stb});
      end
      if (e.hd) begin
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL hold_retired_frozen: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
      @(posedge clk); #1;
      if (e.last) begin
        exp_cnt = exp_cnt + CW'(1);
        checks++;
        if (retired_cnt !== exp_cnt) begin
          failures++; $display("FAIL hold_retired: got=%0d want=%0d", retired_cnt, exp_cnt);
        end
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    ins_in = 32'hFFFF_FFFF;
    test_reset();
    test_alu();
    test_flow();
    test_mem();
    test_illegal();
    test_back_to_back();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_decode_ctrl.md
INS_DECODE_CTRL -- requirements
Module: ins_decode_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of retired_cnt.
REQ-002 The block SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port hold, input, 1: freezes the FSM and all registers while high.
REQ-005 The block SHALL have port ins_in, input, 32: the instruction word from the fetch stage (im_out_ins).
REQ-006 The block SHALL have port npc_sel, output, 1: branch select to the fetch NPC; the fetch stage qualifies it with alu_zero.
REQ-007 The block SHALL have port isJump, output, 1: jump select to the fetch NPC.
REQ-008 The block SHALL have port npc_out_imm16, output, 16, carrying ir[15:0].
REQ-009 The block SHALL have port npc_out_imm26, output, 26, carrying ir[25:0].
REQ-010 The block SHALL have port pc_we, output, 1: a one-cycle PC update strobe to the fetch stage.
REQ-011 The block SHALL have ports rs/rt/rd, output, 5 each, carrying ir[25:21], ir[20:16] and ir[15:11].
REQ-012 The block SHALL have these output ports:
- reg_we, 1
- reg_dst, 1: 1 selects rd, 0 selects rt
- alu_src, 1: 1 selects the immediate
- mem_we, 1
- mem_to_reg, 1
REQ-013 The block SHALL have port alu_op, output, 3, encoded 0 add, 1 sub, 2 or, 3 pass-immediate.
REQ-014 The block SHALL have port ext_op, output, 2, encoded 0 zero-extend, 1 sign-extend, 2 imm16<<16.
REQ-015 The block SHALL have ports illegal_ins (output, 1), state (output, 3) and retired_cnt (output, CNT_W).

Function
REQ-016 The FSM states SHALL be encoded IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-017 In IF, ir SHALL load ins_in and the next state SHALL be ID.
REQ-018 The instruction set SHALL be exactly:
- R-type (opcode 0x00) with funct addu 0x21 and subu 0x23
- ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02
REQ-019 All decoded fields and mux selects SHALL be combinational from the registered ir only, never from ins_in.
REQ-020 The state sequences SHALL be:
- R-type, ori, lui: IF-ID-EX-WB (4 cycles)
- lw: IF-ID-EX-MEM-WB (5 cycles)
- sw: IF-ID-EX-MEM (4 cycles)
- beq: IF-ID-EX (3 cycles)
- j: IF-ID (2 cycles)
REQ-021 pc_we SHALL be high only in the final state of each instruction, for exactly one cycle, and the next state SHALL then be IF.
REQ-022 npc_sel SHALL be 1 only in the EX state of beq, coincident with pc_we.
REQ-023 isJump SHALL be 1 only in the ID state of j, coincident with pc_we.
REQ-024 reg_we SHALL be 1 only in WB.
REQ-025 mem_we SHALL be 1 only in the MEM state of sw.
REQ-026 These strobes SHALL be 0 in every other state.
REQ-027 The selects SHALL be decoded as follows:
- addu: alu_op=0
- subu: alu_op=1
- ori: alu_op=2, ext_op=0
- lui: alu_op=3, ext_op=2
- lw and sw: alu_op=0, ext_op=1
- beq: alu_op=1
REQ-028 alu_src SHALL be 1 for ori, lui, lw and sw.
REQ-029 reg_dst SHALL be 1 only for R-type.
REQ-030 mem_to_reg SHALL be 1 only for lw.
REQ-031 An unknown opcode or funct SHALL:
- pulse illegal_ins for one cycle in ID, coincident with pc_we
- assert no reg_we or mem_we
- return the FSM to IF
REQ-032 retired_cnt SHALL increment by 1 on every pc_we cycle, including for illegal instructions, and SHALL wrap from all-ones to 0.
REQ-033 While hold=1:
- state, ir and retired_cnt SHALL hold their values
- all strobes (pc_we, reg_we, mem_we, npc_sel, isJump, illegal_ins) SHALL be forced to 0
- the pending strobe SHALL be issued once, in the first cycle after hold falls

Reset
REQ-034 While rst=1, state SHALL be IF, ir SHALL be 0, retired_cnt SHALL be 0, and every output SHALL be 0, asynchronously.
REQ-035 rst asserted mid-instruction SHALL abandon that instruction without any strobe.
REQ-036 After rst falls, the first IF SHALL occur on the first clock edge and latch ins_in.

Verification
REQ-037 The bench SHALL cover: ins_in=0x00221821 (addu $3,$1,$2) -> states 0,1,2,4; in the WB cycle reg_we=1, reg_dst=1, rd=3, alu_op=0, pc_we=1; retired_cnt=1.
REQ-038 The bench SHALL cover: ins_in=0x10220004 (beq) -> 3rd cycle has npc_sel=1, pc_we=1, npc_out_imm16=0x0004; no reg_we.
REQ-039 The bench SHALL cover: ins_in=0x08000010 (j) -> 2nd cycle has isJump=1, pc_we=1, npc_out_imm26=0x0000010.
REQ-040 The bench SHALL cover: ins_in=0x8C850008 (lw $5,8($4)) -> states 0,1,2,3,4; in WB reg_we=1, reg_dst=0, rt=5, mem_to_reg=1, ext_op=1, alu_src=1.
REQ-041 The bench SHALL cover: ins_in=0xFC000000 -> illegal_ins=1 and pc_we=1 in ID; reg_we=0 and mem_we=0 throughout; retired_cnt increments.
REQ-042 The bench SHALL cover: rst pulsed during EX of addu -> all outputs 0 immediately; no reg_we; then hold=1 in WB for 3 cycles -> no strobes, and reg_we/pc_we are issued once after release.
